// File: rtl/show_pkg.sv
// Shared types and default timing constants for the light-show sequencer and its pattern blocks.
package show_pkg;

  localparam int unsigned LIGHTS_W = 8;

  localparam int unsigned CLKS_PER_MS_DEFAULT = 5000;
  localparam int unsigned GAP_MS_DEFAULT      = 1000;
  localparam int unsigned TIMEOUT_MS_DEFAULT  = 120000;

  // Note lengths used by the pattern blocks, in ms
  localparam int unsigned NOTE_WHOLE_MS   = 2000;
  localparam int unsigned NOTE_HALF_MS    = 1000;
  localparam int unsigned NOTE_QUARTER_MS = 500;
  localparam int unsigned NOTE_EIGHTH_MS  = 250;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/show_sequencer_next_enabled_idx.sv
// Combinational priority finder: lowest set mask bit above cur_idx, or from bit 0 when from_zero is set.
module next_enabled_idx #(
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned IDX_W        = $clog2(NUM_PATTERNS)
) (
  input  logic [NUM_PATTERNS-1:0] mask,
  input  logic [IDX_W-1:0]        cur_idx,
  input  logic                    from_zero,
  output logic [IDX_W-1:0]        next_idx_c,
  output logic                    valid_c
);

  // Scan downwards so the lowest qualifying bit is the one left standing
  always_comb begin
    next_idx_c = '0;
    valid_c    = 1'b0;
    for (int i = int'(NUM_PATTERNS) - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || (IDX_W'(i) > cur_idx))) begin
        next_idx_c = IDX_W'(i);
        valid_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/show_sequencer.sv
// Light-show scheduler: launches enabled pattern blocks in order, muxes the active one's lights,
// inserts a dark gap between patterns and skips any pattern that overruns its watchdog.
// Build option: SHOW_SEQUENCER_LOOP_EN repeats the show from the lowest enabled pattern forever.
module show_sequencer
  import show_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned CLKS_PER_MS  = CLKS_PER_MS_DEFAULT,
  parameter int unsigned GAP_MS       = GAP_MS_DEFAULT,
  parameter int unsigned TIMEOUT_MS   = TIMEOUT_MS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic [NUM_PATTERNS-1:0]          enable_mask,
  output logic [NUM_PATTERNS-1:0]          pat_go,
  input  logic [NUM_PATTERNS-1:0]          pat_finished,
  input  logic [LIGHTS_W*NUM_PATTERNS-1:0] pat_lights,
  output logic [LIGHTS_W-1:0]              lights,
  output logic [$clog2(NUM_PATTERNS)-1:0]  cur_pattern,
  output logic                             busy,
  output logic                             show_done,
  output logic                             timeout_err
);

  localparam int unsigned IDX_W        = $clog2(NUM_PATTERNS);
  localparam int unsigned MAX_MS       = (TIMEOUT_MS > GAP_MS) ? TIMEOUT_MS : GAP_MS;
  localparam int unsigned CNT_W        = $clog2(MAX_MS * CLKS_PER_MS + 1);
  localparam int unsigned TIMEOUT_LAST = TIMEOUT_MS * CLKS_PER_MS - 1;
  localparam int unsigned GAP_LAST     = GAP_MS * CLKS_PER_MS - 1;

  seq_state_e              state_q, state_d;
  logic [NUM_PATTERNS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]        cur_q, cur_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [NUM_PATTERNS-1:0] go_q, go_d;
  logic [LIGHTS_W-1:0]     lights_q, lights_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    terr_q, terr_d;

  logic [NUM_PATTERNS-1:0] first_mask;
  logic [IDX_W-1:0]        first_idx, nxt_idx;
  logic                    first_vld, nxt_vld;
  logic [LIGHTS_W-1:0]     sel_lights;
  logic                    sel_finished;

  // In IDLE the first pick comes from the live mask; once running it comes from the latched copy
  assign first_mask = (state_q == ST_IDLE) ? enable_mask : mask_q;

  next_enabled_idx #(.NUM_PATTERNS(NUM_PATTERNS), .IDX_W(IDX_W)) u_first (
    .mask       (first_mask),
    .cur_idx    ('0),
    .from_zero  (1'b1),
    .next_idx_c (first_idx),
    .valid_c    (first_vld)
  );

  next_enabled_idx #(.NUM_PATTERNS(NUM_PATTERNS), .IDX_W(IDX_W)) u_next (
    .mask       (mask_q),
    .cur_idx    (cur_q),
    .from_zero  (1'b0),
    .next_idx_c (nxt_idx),
    .valid_c    (nxt_vld)
  );

  // Select the active pattern's light bus
  always_comb begin
    sel_lights = '0;
    for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
      if (cur_q == IDX_W'(i)) sel_lights = pat_lights[i*LIGHTS_W +: LIGHTS_W];
    end
  end

  assign sel_finished = pat_finished[cur_q];
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    go_d     = '0;
    lights_d = '0;
    done_d   = 1'b0;
    terr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (first_vld) begin
            mask_d  = enable_mask;
            cur_d   = first_idx;
            go_d    = NUM_PATTERNS'(1) << first_idx;
            state_d = ST_LAUNCH;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sel_finished) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT_LAST)) begin
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d    = cnt_inc;
          lights_d = sel_lights;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          cnt_d = '0;
          if (nxt_vld) begin
            cur_d   = nxt_idx;
            go_d    = NUM_PATTERNS'(1) << nxt_idx;
            state_d = ST_LAUNCH;
          end else begin
`ifdef SHOW_SEQUENCER_LOOP_EN
            cur_d   = first_idx;
            go_d    = NUM_PATTERNS'(1) << first_idx;
            state_d = ST_LAUNCH;
`else
            done_d  = 1'b1;
            state_d = ST_DONE;
`endif
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything once a show is underway
    if (stop && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      go_d     = '0;
      lights_d = '0;
      done_d   = 1'b0;
      terr_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      go_q     <= '0;
      lights_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      lights_q <= lights_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
    end
  end

  assign pat_go      = go_q;
  assign lights      = lights_q;
  assign cur_pattern = cur_q;
  assign busy        = busy_q;
  assign show_done   = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_show_sequencer.sv
// Directed bench for show_sequencer with a go-order scoreboard.
module tb_show_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned CPM = 4;
  localparam int unsigned GMS = 2;
  localparam int unsigned TMS = 50;

  logic           clk;
  logic           rst;
  logic           start;
  logic           stop;
  logic [N-1:0]   enable_mask;
  logic [N-1:0]   pat_go;
  logic [N-1:0]   pat_finished;
  logic [8*N-1:0] pat_lights;
  logic [7:0]     lights;
  logic [1:0]     cur_pattern;
  logic           busy;
  logic           show_done;
  logic           timeout_err;

  show_sequencer #(
    .NUM_PATTERNS (N),
    .CLKS_PER_MS  (CPM),
    .GAP_MS       (GMS),
    .TIMEOUT_MS   (TMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .enable_mask  (enable_mask),
    .pat_go       (pat_go),
    .pat_finished (pat_finished),
    .pat_lights   (pat_lights),
    .lights       (lights),
    .cur_pattern  (cur_pattern),
    .busy         (busy),
    .show_done    (show_done),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_go[$];
  bit         seen_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every go pulse must match the next expected one-hot
  always @(negedge clk) begin
    if (!rst && (pat_go !== '0)) begin
      if (exp_go.size() == 0) check("unexpected_go", 32'(pat_go), 32'h0);
      else                    check("go_order", 32'(pat_go), 32'(exp_go.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (show_done === 1'b1) seen_done = 1'b1;
  end

  bit dark_ok;
  bit early;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    enable_mask  = '0;
    pat_finished = '0;
    pat_lights   = {8'hC3, 8'h5A, 8'hA5, 8'h3C};
    step();
    step();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_lights", 32'(lights), 32'h0);
    check("rst_go", 32'(pat_go), 32'h0);
    check("rst_done", 32'(show_done), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    check("rst_cur", 32'(cur_pattern), 32'h0);
    rst = 1'b0;
    step();

    // Reset applied mid-RUN
    enable_mask = 4'b0010;
    exp_go.push_back(4'b0010);
    start = 1'b1;
    step();
    start = 1'b0;
    check("mid_launch_cur", 32'(cur_pattern), 32'h1);
    step();
    step();
    check("mid_run_lights", 32'(lights), 32'hA5);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_lights", 32'(lights), 32'h0);
    check("mid_rst_go", 32'(pat_go), 32'h0);
    check("mid_rst_done", 32'(show_done), 32'h0);
    check("mid_rst_cur", 32'(cur_pattern), 32'h0);
    step();
    check("mid_rst_idle", 32'(busy), 32'h0);

`ifndef SHOW_SEQUENCER_LOOP_EN
    // Basic two-pattern show; mask changes while busy must be ignored
    enable_mask = 4'b1010;
    exp_go.push_back(4'b0010);
    exp_go.push_back(4'b1000);
    start = 1'b1;
    step();
    start = 1'b0;
    enable_mask = 4'b1111;
    check("b_go1", 32'(pat_go), 32'h2);
    check("b_cur1", 32'(cur_pattern), 32'h1);
    check("b_busy", 32'(busy), 32'h1);
    step();
    check("b_run_latency", 32'(lights), 32'h0);
    step();
    check("b_lights1", 32'(lights), 32'hA5);
    step();
    step();
    pat_finished = 4'b0010;
    step();
    pat_finished = '0;
    dark_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (lights !== 8'h0 || pat_go !== 4'h0) dark_ok = 1'b0;
      step();
    end
    check("b_gap1_dark", 32'(dark_ok), 32'h1);
    check("b_go3", 32'(pat_go), 32'h8);
    check("b_cur3", 32'(cur_pattern), 32'h3);
    step();
    step();
    check("b_lights3", 32'(lights), 32'hC3);
    pat_finished = 4'b1000;
    step();
    pat_finished = '0;
    dark_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (lights !== 8'h0 || pat_go !== 4'h0 || show_done !== 1'b0) dark_ok = 1'b0;
      step();
    end
    check("b_gap2_dark", 32'(dark_ok), 32'h1);
    check("b_done", 32'(show_done), 32'h1);
    check("b_done_busy", 32'(busy), 32'h1);
    step();
    check("b_done_pulse", 32'(show_done), 32'h0);
    check("b_idle_busy", 32'(busy), 32'h0);
`endif

    // Finished from a non-selected pattern is ignored
    enable_mask = 4'b0001;
    exp_go.push_back(4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    pat_finished = 4'b0100;
    step();
    pat_finished = '0;
    check("f_stay_lights", 32'(lights), 32'h3C);
    check("f_stay_busy", 32'(busy), 32'h1);
    step();
    check("f_lights0", 32'(lights), 32'h3C);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("f_stop_busy", 32'(busy), 32'h0);
    check("f_stop_lights", 32'(lights), 32'h0);

`ifndef SHOW_SEQUENCER_LOOP_EN
    // Watchdog fires after exactly 200 RUN cycles
    exp_go.push_back(4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    early = 1'b0;
    for (int i = 0; i < 199; i++) begin
      step();
      if (timeout_err !== 1'b0) early = 1'b1;
    end
    check("wd_no_early", 32'(early), 32'h0);
    check("wd_still_busy", 32'(busy), 32'h1);
    step();
    check("wd_fire", 32'(timeout_err), 32'h1);
    check("wd_gap_lights", 32'(lights), 32'h0);
    step();
    check("wd_pulse", 32'(timeout_err), 32'h0);
    for (int i = 0; i < 7; i++) step();
    check("wd_done", 32'(show_done), 32'h1);
    step();
    check("wd_idle", 32'(busy), 32'h0);
`endif

    // Finished on the timeout cycle wins; then abort from GAP
    exp_go.push_back(4'b0001);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 199; i++) step();
    pat_finished = 4'b0001;
    step();
    pat_finished = '0;
    check("wd_fin_wins", 32'(timeout_err), 32'h0);
    check("wd_fin_gap", 32'(busy), 32'h1);
    seen_done = 1'b0;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(show_done), 32'h0);
    pat_finished = 4'b0001;
    step();
    pat_finished = '0;
    for (int i = 0; i < 12; i++) step();
    check("abort_no_done", 32'(seen_done), 32'h0);
    check("abort_late_fin", 32'(busy), 32'h0);

    // start and stop together in IDLE: stop wins
    enable_mask = 4'b0001;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 32'(busy), 32'h0);
    step();
    check("ss_go", 32'(pat_go), 32'h0);

`ifndef SHOW_SEQUENCER_LOOP_EN
    // Empty mask completes immediately
    enable_mask = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    check("empty_done", 32'(show_done), 32'h1);
    check("empty_go", 32'(pat_go), 32'h0);
    step();
    check("empty_pulse", 32'(show_done), 32'h0);
    check("empty_idle", 32'(busy), 32'h0);
`else
    // Loop mode: 0,2,0,2 until stop, never show_done
    enable_mask = 4'b0101;
    exp_go.push_back(4'b0001);
    exp_go.push_back(4'b0100);
    exp_go.push_back(4'b0001);
    exp_go.push_back(4'b0100);
    seen_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("loop_go0a", 32'(pat_go), 32'h1);
    step();
    pat_finished = 4'b0001;
    step();
    pat_finished = '0;
    for (int i = 0; i < 8; i++) step();
    check("loop_go2a", 32'(pat_go), 32'h4);
    step();
    pat_finished = 4'b0100;
    step();
    pat_finished = '0;
    for (int i = 0; i < 8; i++) step();
    check("loop_go0b", 32'(pat_go), 32'h1);
    step();
    pat_finished = 4'b0001;
    step();
    pat_finished = '0;
    for (int i = 0; i < 8; i++) step();
    check("loop_go2b", 32'(pat_go), 32'h4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'h0);
    check("loop_no_done", 32'(seen_done), 32'h0);
`endif

    step();
    check("go_queue_empty", 32'(exp_go.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
